// File: rtl/safecrack_pkg.sv
// Shared types and constants for the safecrack lock and its input conditioning stage.
package safecrack_pkg;

    localparam int unsigned BTN_W           = 4;
    localparam logic [BTN_W-1:0] BTN_IDLE   = 4'b1111;
    localparam int unsigned DB_CYCLES_DEF   = 500000;
    localparam int unsigned TICK_CYCLES_DEF = 50000000;

    typedef enum logic {
        IDLE,
        HELD
    } cond_state_t;

    // One-cold code for the lowest-index pressed button; BTN_IDLE when none.
    function automatic logic [BTN_W-1:0] press_code(input logic [BTN_W-1:0] press);
        logic [BTN_W-1:0] code;
        logic             found;
        code  = BTN_IDLE;
        found = 1'b0;
        for (int i = 0; i < BTN_W; i++) begin
            if (press[i] && !found) begin
                code[i] = 1'b0;
                found   = 1'b1;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/safecrack_input_cond_if.sv
// Raw button/switch inputs and conditioned outputs of the input conditioning stage.
interface safecrack_input_cond_if;
    import safecrack_pkg::*;

    logic [BTN_W-1:0] btn_raw;
    logic             ms_raw;
    logic             tick_clr;
    logic [BTN_W-1:0] btn_evt;
    logic             ms_level;
    logic             sec_tick;

    modport master (
        output btn_raw, ms_raw, tick_clr,
        input  btn_evt, ms_level, sec_tick
    );

    modport slave (
        input  btn_raw, ms_raw, tick_clr,
        output btn_evt, ms_level, sec_tick
    );

endinterface

// File: rtl/safecrack_debounce.sv
// Two-flop synchronizer followed by a counter debouncer that flips its level
// only after the synchronized input has differed for DB_CYCLES consecutive cycles.
module safecrack_debounce #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter logic        RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            cnt   <= '0;
            level <= RST_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the held level restarts the stability window.
            if (sync2 != level) begin
                if (cnt == CNT_W'(DB_CYCLES)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/safecrack_input_cond.sv
// Input conditioning for the safecrack lock: debounced buttons turned into
// single-cycle one-cold press codes, a debounced mode switch, and a 1 s tick.
module safecrack_input_cond
    import safecrack_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    safecrack_input_cond_if.slave  io
);

    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

    logic [BTN_W-1:0]  btn_lvl;
    logic [BTN_W-1:0]  btn_lvl_q;
    logic [BTN_W-1:0]  press_c;
    logic              all_rel_c;
    logic              ms_lvl;
    cond_state_t       state;
    logic [BTN_W-1:0]  btn_evt_q;
    logic [TICK_W-1:0] tick_cnt;
    logic              sec_tick_q;

    for (genvar g = 0; g < BTN_W; g++) begin : g_btn_db
        safecrack_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (1'b1)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (io.btn_raw[g]),
            .level (btn_lvl[g])
        );
    end

    safecrack_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (1'b0)
    ) u_ms_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (io.ms_raw),
        .level (ms_lvl)
    );

    // Press = falling edge of a debounced (active-low) button level.
    assign press_c   = btn_lvl_q & ~btn_lvl;
    assign all_rel_c = &btn_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            btn_evt_q <= BTN_IDLE;
            btn_lvl_q <= BTN_IDLE;
        end else begin
            btn_lvl_q <= btn_lvl;
            btn_evt_q <= BTN_IDLE;
            case (state)
                IDLE: begin
                    if (|press_c) begin
                        btn_evt_q <= press_code(press_c);
                        state     <= HELD;
                    end
                end
                HELD: begin
                    if (all_rel_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Second counter; a clear wins over the wrap and suppresses that tick.
    always_ff @(posedge clk) begin
        if (rst || io.tick_clr) begin
            tick_cnt   <= '0;
            sec_tick_q <= 1'b0;
        end else if (tick_cnt == TICK_W'(TICK_CYCLES - 1)) begin
            tick_cnt   <= '0;
            sec_tick_q <= 1'b1;
        end else begin
            tick_cnt   <= tick_cnt + TICK_W'(1);
            sec_tick_q <= 1'b0;
        end
    end

    assign io.btn_evt  = btn_evt_q;
    assign io.ms_level = ms_lvl;
    assign io.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_safecrack_input_cond.sv
// Directed bench for safecrack_input_cond with DB_CYCLES=4, TICK_CYCLES=10.
module tb_safecrack_input_cond;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned cyc;
    int unsigned ev_cnt;
    logic [3:0]  ev_val;
    int unsigned ev_idx;
    int unsigned tk_cnt;
    int unsigned tk_first;
    int unsigned tk_last;
    logic        found;

    safecrack_input_cond_if io ();

    safecrack_input_cond #(
        .DB_CYCLES   (4),
        .TICK_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_watch();
        cyc      = 0;
        ev_cnt   = 0;
        ev_val   = 4'b1111;
        ev_idx   = 0;
        tk_cnt   = 0;
        tk_first = 0;
        tk_last  = 0;
    endtask

    // Advance one clock, sample just after the edge and log events/ticks.
    task automatic step(input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (io.btn_evt !== 4'b1111) begin
                ev_cnt++;
                if (ev_cnt == 1) begin
                    ev_val = io.btn_evt;
                    ev_idx = cyc;
                end
            end
            if (io.sec_tick === 1'b1) begin
                tk_cnt++;
                if (tk_cnt == 1) tk_first = cyc;
                tk_last = cyc;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        io.btn_raw  = 4'b1111;
        io.ms_raw   = 1'b0;
        io.tick_clr = 1'b0;
        clr_watch();

        // 1. reset state and idle buttons
        step(3);
        check("rst_btn_evt", 32'(io.btn_evt), 32'hF);
        check("rst_ms_level", 32'(io.ms_level), 32'h0);
        check("rst_sec_tick", 32'(io.sec_tick), 32'h0);
        rst = 1'b0;
        clr_watch();
        step(50);
        check("idle_no_event", ev_cnt, 0);

        // 2. single presses
        clr_watch();
        io.btn_raw = 4'b1110;
        step(20);
        check("p0_count", ev_cnt, 1);
        check("p0_code", 32'(ev_val), 32'hE);
        check("p0_latency", ev_idx, 8);
        io.btn_raw = 4'b1111;
        step(10);
        clr_watch();
        io.btn_raw = 4'b1101;
        step(20);
        check("p1_count", ev_cnt, 1);
        check("p1_code", 32'(ev_val), 32'hD);
        check("p1_latency", ev_idx, 8);
        io.btn_raw = 4'b1111;
        step(12);

        // 3. bounce shorter than the window, then a clean press
        clr_watch();
        io.btn_raw = 4'b1101; step(3);
        io.btn_raw = 4'b1111; step(1);
        io.btn_raw = 4'b1101; step(3);
        io.btn_raw = 4'b1111; step(12);
        check("bounce_no_event", ev_cnt, 0);
        clr_watch();
        io.btn_raw = 4'b1101; step(8);
        io.btn_raw = 4'b1111; step(12);
        check("bounce_clean_count", ev_cnt, 1);
        check("bounce_clean_code", 32'(ev_val), 32'hD);
        check("bounce_clean_latency", ev_idx, 8);

        // 4. simultaneous press, extra press while held, then new press
        clr_watch();
        io.btn_raw = 4'b1100; step(12);
        check("simul_count", ev_cnt, 1);
        check("simul_code", 32'(ev_val), 32'hE);
        check("simul_latency", ev_idx, 8);
        io.btn_raw = 4'b0100; step(12);
        check("held_no_extra", ev_cnt, 1);
        clr_watch();
        io.btn_raw = 4'b1111; step(6);
        io.btn_raw = 4'b1011; step(14);
        check("after_rel_count", ev_cnt, 1);
        check("after_rel_code", 32'(ev_val), 32'hB);
        check("after_rel_latency", ev_idx, 14);
        io.btn_raw = 4'b1111; step(12);

        // 5. second tick period and clear
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (io.sec_tick === 1'b1) found = 1'b1;
        end
        check("tick_found", 32'(found), 32'h1);
        clr_watch();
        step(34);
        check("tick_count", tk_cnt, 3);
        check("tick_first", tk_first, 10);
        check("tick_last", tk_last, 30);
        clr_watch();
        io.tick_clr = 1'b1; step(1);
        io.tick_clr = 1'b0; step(14);
        check("tick_clr_count", tk_cnt, 1);
        check("tick_clr_first", tk_first, 11);

        // 6. switch latency, then reset during a fresh press
        clr_watch();
        io.ms_raw = 1'b1;
        step(6);
        check("ms_before", 32'(io.ms_level), 32'h0);
        step(1);
        check("ms_after", 32'(io.ms_level), 32'h1);
        clr_watch();
        io.btn_raw = 4'b1110;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_btn_evt", 32'(io.btn_evt), 32'hF);
        check("midrst_ms_level", 32'(io.ms_level), 32'h0);
        check("midrst_sec_tick", 32'(io.sec_tick), 32'h0);
        check("midrst_no_early", ev_cnt, 0);
        clr_watch();
        step(20);
        check("postrst_count", ev_cnt, 1);
        check("postrst_code", 32'(ev_val), 32'hE);
        check("postrst_latency", ev_idx, 8);
        io.btn_raw = 4'b1111;
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
